// File: rtl/ps2_pkg.sv
// ps2_pkg: shared FSM state type and special scan-code constants for the PS/2 receiver
package ps2_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_e;
  localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;
  localparam logic [7:0] PS2_EXT_CODE = 8'hE0;
endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: synchronises the PS/2 clock/data lines and flags ps2_clock falling edges
// Ports: clk/rst system clock and sync reset; i_clk_line/i_data_line raw lines;
//        o_fall one-cycle falling-edge pulse; o_data synchronised data aligned with o_fall.
// Flops reset to 1 so idle-high lines never produce an edge straight out of reset.
module ps2_line_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clk_line,
  input  logic i_data_line,
  output logic o_fall,
  output logic o_data
);
  logic [STAGES-1:0] r_clk_sync, r_data_sync;
  logic r_clk_prev;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_sync <= '1;
      r_data_sync <= '1;
      r_clk_prev <= 1'b1;
      o_fall <= 1'b0;
      o_data <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[STAGES-2:0], i_clk_line};
      r_data_sync <= {r_data_sync[STAGES-2:0], i_data_line};
      r_clk_prev <= r_clk_sync[STAGES-1];
      o_fall <= r_clk_prev & ~r_clk_sync[STAGES-1];
      o_data <= r_data_sync[STAGES-1];
    end
  end
endmodule

// File: rtl/ps2_interface.sv
// ps2_interface: receive-only PS/2 keyboard deframer with make/break tracking
// Ports: clock/reset system clock and sync active-high reset; ps2_clock/ps2_data open-drain
//        lines, read only; ps2_key_data last valid byte; ps2_key_pressed one-cycle strobe per
//        valid byte; ps2_out last make scan code.
// Build option: define PS2_PARITY_CHECK_EN to also require odd parity for a valid frame.
module ps2_interface
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic clock,
  input  logic reset,
  inout  wire  ps2_clock,
  inout  wire  ps2_data,
  output logic [7:0] ps2_key_data,
  output logic ps2_key_pressed,
  output logic [7:0] ps2_out
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_CHK = 1'b1;
`else
  localparam bit PAR_CHK = 1'b0;
`endif
  ps2_state_e r_state, w_next;
  logic [7:0] r_shift;
  logic [2:0] r_bits;
  logic r_parity, r_break;
  logic [CW-1:0] r_cnt;
  logic w_fall, w_data, w_timeout, w_valid;
  ps2_line_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk(clock),
    .rst(reset),
    .i_clk_line(ps2_clock),
    .i_data_line(ps2_data),
    .o_fall(w_fall),
    .o_data(w_data)
  );
  // a stalled partial frame wins over a coincident edge so it is always abandoned cleanly
  assign w_timeout = r_state != IDLE && r_cnt == CW'(TIMEOUT_CYCLES);
  assign w_valid = w_fall && !w_timeout && r_state == STOP && w_data && (!PAR_CHK || ^{r_shift, r_parity});
  always_comb begin
    w_next = r_state;
    if (w_timeout)
      w_next = IDLE;
    else if (w_fall)
      case (r_state)
        IDLE:    w_next = w_data ? IDLE : DATA;
        DATA:    w_next = r_bits == 3'd7 ? PARITY : DATA;
        PARITY:  w_next = STOP;
        default: w_next = IDLE;
      endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_bits <= '0;
      r_parity <= 1'b0;
      r_break <= 1'b0;
      r_cnt <= '0;
      ps2_key_data <= 8'h00;
      ps2_key_pressed <= 1'b0;
      ps2_out <= 8'h00;
    end else begin
      r_state <= w_next;
      r_cnt <= w_fall ? '0 : r_cnt == CW'(TIMEOUT_CYCLES) ? r_cnt : r_cnt + 1'b1;
      ps2_key_pressed <= w_valid;
      if (w_fall && !w_timeout) begin
        if (r_state == IDLE) r_bits <= '0;
        if (r_state == DATA) begin
          r_shift <= {w_data, r_shift[7:1]};
          r_bits <= r_bits + 1'b1;
        end
        if (r_state == PARITY) r_parity <= w_data;
      end
      if (w_valid) begin
        ps2_key_data <= r_shift;
        // F0 arms a break; the next ordinary byte is the released key and is not a make
        if (r_shift == PS2_BREAK_CODE)
          r_break <= 1'b1;
        else if (r_shift != PS2_EXT_CODE) begin
          if (r_break) r_break <= 1'b0;
          else ps2_out <= r_shift;
        end
      end
    end
  end
endmodule

// File: tb/tb_ps2_interface.sv
// tb_ps2_interface: randomized PS/2 frame stimulus checked against a byte-level reference model
module tb_ps2_interface;
  localparam int TO = 300;
  localparam int HP = 25;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif
  logic clock = 1'b0, reset = 1'b1, c_line = 1'b1, d_line = 1'b1;
  wire ps2_clock_w, ps2_data_w;
  logic [7:0] ps2_key_data, ps2_out;
  logic ps2_key_pressed;
  int checks = 0, errors = 0, n_strobe = 0, exp_strobes = 0, run = 0;
  logic [7:0] exp_key = 8'h00, exp_out = 8'h00;
  logic brk = 1'b0;
  logic [7:0] expq[$];
  assign ps2_clock_w = c_line;
  assign ps2_data_w = d_line;
  ps2_interface #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock),
    .reset(reset),
    .ps2_clock(ps2_clock_w),
    .ps2_data(ps2_data_w),
    .ps2_key_data(ps2_key_data),
    .ps2_key_pressed(ps2_key_pressed),
    .ps2_out(ps2_out)
  );
  always #50 clock = ~clock;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic ps2_bit(input logic b);
    d_line = b;
    cyc(HP);
    c_line = 1'b0;
    cyc(HP);
    c_line = 1'b1;
  endtask
  always @(negedge clock) begin
    if (ps2_key_pressed) begin
      run++;
      if (run == 1) begin
        n_strobe++;
        if (expq.size() == 0) chk("unexpected_strobe", 1, 0);
        else chk("strobe_byte", ps2_key_data, expq.pop_front());
      end
    end else if (run != 0) begin
      chk("pulse_len", run, 1);
      run = 0;
    end
  end
  task automatic frame(input logic [7:0] b, input logic stop, input logic pflip, input int nbits);
    logic v;
    v = nbits == 8 && stop && !(PCHK && pflip);
    if (v) begin
      expq.push_back(b);
      exp_strobes++;
      exp_key = b;
      if (b == 8'hF0) brk = 1'b1;
      else if (b != 8'hE0) begin
        if (brk) brk = 1'b0;
        else exp_out = b;
      end
    end
    ps2_bit(1'b0);
    for (int i = 0; i < nbits; i++) ps2_bit(b[i]);
    if (nbits == 8) begin
      ps2_bit(~^b ^ pflip);
      ps2_bit(stop);
    end
    d_line = 1'b1;
    cyc(2 * HP);
    if (nbits < 8) cyc(TO + 20);
    chk("strobes", n_strobe, exp_strobes);
    chk("key_data", ps2_key_data, exp_key);
    chk("ps2_out", ps2_out, exp_out);
  endtask
  initial begin
    logic [7:0] b;
    int sel, err;
    cyc(5);
    chk("rst_key_data", ps2_key_data, 0);
    chk("rst_pressed", ps2_key_pressed, 0);
    chk("rst_out", ps2_out, 0);
    reset = 1'b0;
    cyc(5);
    frame(8'h1C, 1, 0, 8);
    frame(8'h1C, 1, 0, 8);
    frame(8'hF0, 1, 0, 8);
    frame(8'h1C, 1, 0, 8);
    frame(8'h32, 1, 0, 8);
    frame(8'h24, 0, 0, 8);
    frame(8'h24, 1, 0, 8);
    frame(8'h32, 1, 0, 4);
    frame(8'h32, 1, 0, 8);
    frame(8'hF0, 1, 0, 8);
    b = 8'h45;
    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(b[i]);
    reset = 1'b1;
    cyc(1);
    chk("midrst_key_data", ps2_key_data, 0);
    chk("midrst_pressed", ps2_key_pressed, 0);
    chk("midrst_out", ps2_out, 0);
    expq.delete();
    exp_key = 8'h00;
    exp_out = 8'h00;
    brk = 1'b0;
    c_line = 1'b1;
    d_line = 1'b1;
    cyc(5);
    reset = 1'b0;
    cyc(5);
    frame(8'h45, 1, 0, 8);
    frame(8'h1C, 1, 1, 8);
    frame(8'hE0, 1, 0, 8);
    frame(8'h75, 1, 0, 8);
    for (int k = 0; k < 40; k++) begin
      sel = $urandom_range(0, 5);
      err = $urandom_range(0, 7);
      b = sel == 0 ? 8'hF0 : sel == 1 ? 8'hE0 : 8'($urandom);
      if (err == 0) frame(b, 0, 0, 8);
      else if (err == 1) frame(b, 1, 1, 8);
      else if (err == 2) frame(b, 1, 0, $urandom_range(0, 7));
      else frame(b, 1, 0, 8);
    end
    chk("queue_drained", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
